apb_master_32bit: RTL and testbench
===================================

# apb_master_32bit

Single-outstanding APB master bridge that turns a valid/ready request channel into APB SETUP/ACCESS transfers and returns one response per request on a valid/ready response channel. Sits directly upstream of the 32-bit APB slave register file and drives its p_* bus. Adds wait-state handling, error forwarding and an ACCESS-phase timeout.

## Interface
- AddrBits, 32, width of req_addr / p_addr
- TimeoutCycles, 16, maximum ACCESS-phase cycles before abort (≥2)
- p_clk  in  1  clock, all logic on rising edge
- p_resetn  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  AddrBits  byte address
- req_write  in  1  1=write, 0=read
- req_wdata  in  32  write data
- req_strb  in  4  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  32  read data (0 for writes/timeouts)
- rsp_err  out  1  p_slverr seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- p_addr, p_write, p_wdata, p_strb  out  AddrBits/1/32/4  APB request fields
- p_sel, p_enable  out  1  APB phase controls
- p_rdata  in  32, p_ready  in  1, p_slverr  in  1  APB completion

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1 (forced 0 while p_resetn=0). On req_valid&req_ready capture addr/write/wdata/strb -> SETUP.
- SETUP: p_sel=1, p_enable=0, one cycle -> ACCESS; timeout counter cleared.
- ACCESS: p_sel=1, p_enable=1. p_ready=1 -> capture rsp_rdata=p_rdata (reads) or 0 (writes), rsp_err=p_slverr, rsp_timeout=0 -> RESP. p_ready=0 -> counter+1; when counter reaches TimeoutCycles-1 with p_ready=0 -> rsp_rdata=0, rsp_err=1, rsp_timeout=1 -> RESP.
- p_ready and timeout in same cycle: p_ready wins.
- RESP: p_sel=p_enable=0, rsp_valid=1, rsp_* stable until rsp_ready -> IDLE.
- p_addr/p_write/p_wdata/p_strb held constant from SETUP through end of ACCESS; reads drive p_strb=0, p_wdata=0.
- Outside SETUP/ACCESS p_sel=p_enable=0; p_* fields keep last values.
- Counter width $clog2(TimeoutCycles+1); never wraps.

## Timing
- Reset (p_resetn=0 at an edge): state IDLE; all outputs 0 (req_ready 0 during reset, 1 first cycle after release); counter and captured fields 0. Reset mid-ACCESS aborts without response.
- Request accepted at edge t: SETUP in cycle t+1, ACCESS from t+2.
- Zero-wait slave: p_ready in t+2, rsp_valid from t+3; with rsp_ready=1, IDLE at t+4, next accept at t+4 edge earliest. Minimum 4 cycles per transfer.
- N wait states: rsp_valid at t+3+N.
- Timeout: ACCESS lasts exactly TimeoutCycles cycles, rsp_valid next cycle.
- req_valid ignored outside IDLE; no combinational path req_* -> p_*, p_* -> rsp_*.

## Structure
- Package apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP), response struct {rdata, err, timeout}, APB_DATA_W=32, APB_STRB_W=4.
- Single flat module; no sub-modules. Bench instantiates it with the APB slave (NumWords=64).

## Test plan
- Write addr 0x04, wdata 0xDEADBEEF, strb 4'hF against slave -> SETUP t+1, ACCESS t+2, rsp_valid t+3, rsp_err=0; read addr 0x04 -> rsp_rdata=0xDEADBEEF.
- Write strb 4'b0011 wdata 0x11223344 over 0xFFFFFFFF, then read -> 0xFFFF3344; read p_strb observed 0.
- Write addr 63 strb 4'hF -> p_slverr, rsp_err=1, rsp_timeout=0, memory unchanged.
- Stub slave holds p_ready=0, TimeoutCycles=16 -> exactly 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; stub with 3 wait states -> rsp_valid at t+6.
- rsp_ready low 5 cycles -> rsp_* stable, req_ready=0, second req_valid not accepted until RESP completes.
- p_resetn=0 during ACCESS -> next edge p_sel=p_enable=rsp_valid=0, no response; req_ready=1 cycle after release.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and widths for the APB master bridge
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_32bit_if.sv
// rtl/apb_master_32bit_if.sv - request/response channels and APB bus of the master bridge
interface apb_master_32bit_if #(
  parameter int AddrBits = 32
) ();
  import apb_pkg::*;

  // request channel
  logic                  req_valid;
  logic                  req_ready;
  logic [AddrBits-1:0]   req_addr;
  logic                  req_write;
  logic [APB_DATA_W-1:0] req_wdata;
  logic [APB_STRB_W-1:0] req_strb;

  // response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // APB bus
  logic [AddrBits-1:0]   p_addr;
  logic                  p_write;
  logic [APB_DATA_W-1:0] p_wdata;
  logic [APB_STRB_W-1:0] p_strb;
  logic                  p_sel;
  logic                  p_enable;
  logic [APB_DATA_W-1:0] p_rdata;
  logic                  p_ready;
  logic                  p_slverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output p_addr, p_write, p_wdata, p_strb, p_sel, p_enable,
    input  p_rdata, p_ready, p_slverr
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  p_addr, p_write, p_wdata, p_strb, p_sel, p_enable,
    output p_rdata, p_ready, p_slverr
  );

endinterface

// File: rtl/apb_master_32bit.sv
// rtl/apb_master_32bit.sv - single-outstanding APB master with wait states, error forwarding and ACCESS timeout
module apb_master_32bit
  import apb_pkg::*;
#(
  parameter int AddrBits      = 32,
  parameter int TimeoutCycles = 16
) (
  input logic               p_clk,
  input logic               p_resetn,
  apb_master_32bit_if.master bus
);

  localparam int             CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  apb_state_e            state_q;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       cnt_d;
  logic                  timeout_hit;
  apb_rsp_t              rsp_q;
  logic                  rsp_valid_q;

  logic [AddrBits-1:0]   p_addr_q;
  logic                  p_write_q;
  logic [APB_DATA_W-1:0] p_wdata_q;
  logic [APB_STRB_W-1:0] p_strb_q;
  logic                  p_sel_q;
  logic                  p_enable_q;

  // next wait-state count and the last-allowed-ACCESS-cycle detect
  always_comb begin
    cnt_d       = cnt_q + CntW'(1);
    timeout_hit = (cnt_q == CntLast);
  end

  // transfer FSM; every bus and response output is a register
  always_ff @(posedge p_clk) begin
    if (!p_resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      p_addr_q    <= '0;
      p_write_q   <= 1'b0;
      p_wdata_q   <= '0;
      p_strb_q    <= '0;
      p_sel_q     <= 1'b0;
      p_enable_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            // reads put zero on the write lanes so the slave never sees stale strobes
            p_addr_q   <= bus.req_addr;
            p_write_q  <= bus.req_write;
            p_wdata_q  <= bus.req_write ? bus.req_wdata : '0;
            p_strb_q   <= bus.req_write ? bus.req_strb : '0;
            p_sel_q    <= 1'b1;
            p_enable_q <= 1'b0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          p_enable_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= ACCESS;
        end
        ACCESS: begin
          // a slave completion in the last allowed cycle beats the timeout
          if (bus.p_ready) begin
            rsp_q.rdata   <= p_write_q ? '0 : bus.p_rdata;
            rsp_q.err     <= bus.p_slverr;
            rsp_q.timeout <= 1'b0;
            p_sel_q       <= 1'b0;
            p_enable_q    <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (timeout_hit) begin
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            p_sel_q       <= 1'b0;
            p_enable_q    <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE) && p_resetn;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_q.rdata;
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;
  assign bus.p_addr      = p_addr_q;
  assign bus.p_write     = p_write_q;
  assign bus.p_wdata     = p_wdata_q;
  assign bus.p_strb      = p_strb_q;
  assign bus.p_sel       = p_sel_q;
  assign bus.p_enable    = p_enable_q;

endmodule

// File: tb/tb_apb_master_32bit.sv
// tb/tb_apb_master_32bit.sv - scoreboard bench for the APB master against a behavioural register-file slave
module tb_apb_master_32bit;
  import apb_pkg::*;

  logic p_clk;
  logic p_resetn;

  apb_master_32bit_if #(.AddrBits(32)) bus ();

  apb_master_32bit #(
    .AddrBits     (32),
    .TimeoutCycles(16)
  ) dut (
    .p_clk   (p_clk),
    .p_resetn(p_resetn),
    .bus     (bus.master)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  // behavioural slave: 64 words, error on misaligned or out-of-range address
  logic [31:0] mem [64];
  int          wait_states;
  bit          hang;
  int          wcnt;
  logic        s_acc, s_err, s_ready;
  logic [31:0] s_rdata;

  always_comb begin
    s_acc   = bus.p_sel && bus.p_enable;
    s_err   = (bus.p_addr[1:0] != 2'b00) || (bus.p_addr >= 32'd256);
    s_ready = s_acc && !hang && (wcnt >= wait_states);
    s_rdata = (s_acc && !s_err) ? mem[bus.p_addr[7:2]] : 32'h0;
  end

  assign bus.p_ready  = s_ready;
  assign bus.p_slverr = s_ready && s_err;
  assign bus.p_rdata  = s_rdata;

  always @(posedge p_clk) begin
    if (!p_resetn) begin
      wcnt <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else begin
      wcnt <= (s_acc && !s_ready) ? wcnt + 1 : 0;
      if (s_ready && !s_err && bus.p_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.p_strb[b]) mem[bus.p_addr[7:2]][b*8 +: 8] <= bus.p_wdata[b*8 +: 8];
      end
    end
  end

  int n_pass;
  int n_total;
  apb_rsp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // monitor: compare every consumed response against the scoreboard
  always begin
    apb_rsp_t e;
    @(negedge p_clk);
    #1;
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
        chk("rsp_timeout", {31'h0, bus.rsp_timeout}, {31'h0, e.timeout});
      end
    end
  end

  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] e_rdata, input logic e_err,
                      input logic e_to, input int e_lat, input bit drain);
    apb_rsp_t e;
    int n, lat, acc;
    @(negedge p_clk);
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge p_clk);
      n++;
    end
    chk("req_accept", {31'h0, bus.req_ready}, 32'd1);
    e.rdata   = e_rdata;
    e.err     = e_err;
    e.timeout = e_to;
    exp_q.push_back(e);
    @(negedge p_clk);
    bus.req_valid = 1'b0;
    chk("setup_phase", {30'h0, bus.p_sel, bus.p_enable}, 32'd2);
    chk("p_addr", bus.p_addr, addr);
    chk("p_strb", {28'h0, bus.p_strb}, wr ? {28'h0, strb} : 32'h0);
    chk("p_wdata", bus.p_wdata, wr ? wdata : 32'h0);
    lat = 0;
    acc = 0;
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge p_clk);
      lat++;
      if (bus.p_sel && bus.p_enable) begin
        acc++;
        if (bus.p_addr !== addr) chk("p_addr_hold", bus.p_addr, addr);
      end
    end
    chk("rsp_latency", lat, e_lat);
    chk("access_cycles", acc, e_lat - 1);
    if (drain) begin
      n = 0;
      while (bus.rsp_valid && n < 50) begin
        @(negedge p_clk);
        n++;
      end
      chk("rsp_drained", {31'h0, bus.rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass        = 0;
    n_total       = 0;
    wait_states   = 0;
    hang          = 1'b0;
    p_resetn      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge p_clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("rst_p_sel", {30'h0, bus.p_sel, bus.p_enable}, 32'd0);
    chk("rst_p_addr", bus.p_addr, 32'h0);
    p_resetn = 1'b1;
    @(posedge p_clk);
    #1;
    chk("rel_req_ready", {31'h0, bus.req_ready}, 32'd1);

    // full write then read back
    xfer(32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, 2, 1'b1);
    xfer(32'h04, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0, 2, 1'b1);

    // partial strobe merge
    xfer(32'h08, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b0, 2, 1'b1);
    xfer(32'h08, 1'b1, 32'h11223344, 4'b0011, 32'h0, 1'b0, 1'b0, 2, 1'b1);
    xfer(32'h08, 1'b0, 32'h0, 4'h0, 32'hFFFF3344, 1'b0, 1'b0, 2, 1'b1);

    // slave error on misaligned write, word left untouched
    xfer(32'd63, 1'b1, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b1, 1'b0, 2, 1'b1);
    xfer(32'd60, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 2, 1'b1);

    // stuck slave: 16 ACCESS cycles then timeout
    hang = 1'b1;
    xfer(32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 17, 1'b1);
    hang = 1'b0;

    // three wait states
    wait_states = 3;
    xfer(32'h04, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0, 5, 1'b1);
    wait_states = 0;

    // response back-pressure: outputs hold, second request not taken
    bus.rsp_ready = 1'b0;
    xfer(32'h08, 1'b0, 32'h0, 4'h0, 32'hFFFF3344, 1'b0, 1'b0, 2, 1'b0);
    bus.req_addr  = 32'h0C;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h55555555;
    bus.req_strb  = 4'hF;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge p_clk);
      chk("stall_rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", bus.rsp_rdata, 32'hFFFF3344);
      chk("stall_req_ready", {31'h0, bus.req_ready}, 32'd0);
      chk("stall_p_sel", {31'h0, bus.p_sel}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge p_clk);
    chk("stall_release", {31'h0, bus.rsp_valid}, 32'd0);
    xfer(32'h0C, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 2, 1'b1);

    // reset in the middle of ACCESS aborts without a response
    hang = 1'b1;
    @(negedge p_clk);
    bus.req_addr  = 32'h10;
    bus.req_write = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge p_clk);
    bus.req_valid = 1'b0;
    @(negedge p_clk);
    @(negedge p_clk);
    chk("pre_rst_access", {30'h0, bus.p_sel, bus.p_enable}, 32'd3);
    p_resetn = 1'b0;
    @(negedge p_clk);
    chk("midrst_p_sel", {30'h0, bus.p_sel, bus.p_enable}, 32'd0);
    chk("midrst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'h0, bus.req_ready}, 32'd0);
    p_resetn = 1'b1;
    hang     = 1'b0;
    @(posedge p_clk);
    #1;
    chk("midrst_rel_ready", {31'h0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge p_clk);
    chk("no_rsp_after_rst", {31'h0, bus.rsp_valid}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
